i2s_sound_serializer: RTL and testbench
=======================================

# i2s_sound_serializer

Downstream stage of the dual OPL2 sound block. Takes the two signed 16-bit channel outputs (left = OPL2 #0, right = OPL2 #1) and applies a per-channel 4-bit gain with saturation. It then serializes the result as a standard Philips I2S stream (BCLK/LRCLK/SDATA) for the cartridge audio DAC. All timing is derived from the system clock by an integer divider, and one stereo frame is captured per I2S frame.

## Interface
- BCLK_DIV, 4: clk cycles per BCLK half-period; legal range 1..255.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  clock enable; low freezes all state
- sound_in_l  in  16  signed left sample, held stable by upstream between updates
- sound_in_r  in  16  signed right sample
- vol_l  in  4  left gain code, unsigned; 8 = unity
- vol_r  in  4  right gain code
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- frame_start  out  1  one-clk pulse when a new frame is captured

## Operation
- **Gain stage (per channel):**
  - Compute p = sound_in × {1'b0, vol} as a 21-bit signed product.
  - Compute q = p >>> 3, an arithmetic shift that floors toward −∞, giving 18 bits.
  - Clamp q to [−32768, 32767] to produce g[15:0].
  - Gain range is 0 to 1.875 in steps of 1/8; vol = 0 gives exact 0.
  - Registered, 2-clk latency, advancing only while enable = 1.
- **Divider:** div_cnt counts 0..BCLK_DIV−1. On the wrap, i2s_bclk toggles.
- **Slot counter:** slot[4:0] counts 0..31 and wraps. It advances on every BCLK falling-edge event, i.e. the divider wrap where i2s_bclk goes 1→0.
- **Word select:** i2s_lrclk = slot[4]. Left occupies slots 0..15, right occupies slots 16..31.
- **Capture:** on the falling-edge event where slot wraps 31→0:
  - frame_word[31:0] ← {g_l, g_r}.
  - frame_start pulses for that one clk.
- **Data (I2S one-BCLK delay):**
  - In slot s, i2s_sdata = frame_word[32−s] for s = 1..31.
  - In slot 0, i2s_sdata = bit 0 of the previous frame_word, i.e. the right-channel LSB.
  - Implement as a 33-bit shift path. i2s_sdata changes only on BCLK falling-edge events.
- **Volume changes:** vol changes take effect at the next capture. There is no mid-frame glitch because frame_word is stable for the whole frame.
- **enable = 0:** all registers hold, including the gain pipeline, divider and outputs. Output levels freeze. frame_start is forced 0 while enable = 0.

## Timing
- **Reset values (async assert, removal synchronous to clk):** i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_start=0, div_cnt=0, slot=0, frame_word=0, gain pipeline=0.
- **Output registering:** all outputs come straight from flops, with no combinational path from inputs.
- **BCLK:** period = 2·BCLK_DIV clk.
- **Frame:** 32 BCLK = 64·BCLK_DIV clk.
- **Sample rate:** f_clk / (64·BCLK_DIV).
- **First frame after reset:**
  - First falling-edge event occurs at clk 2·BCLK_DIV after reset release (rise at BCLK_DIV, fall at 2·BCLK_DIV). It moves slot 0→1.
  - First capture occurs at the 32nd falling-edge event, so the first frame transmits zeros.
- **Input-to-output latency:** an input change propagates to g within 2 enabled clks, and is captured at the next frame boundary at least 2 clks later.
- **Multi-update:** with multiple upstream updates per frame, only the value present at capture is sent; no averaging.
- **Reset mid-frame:** outputs return immediately to reset values. The stream restarts at slot 0 after release; the partial frame is discarded.
- **BCLK_DIV = 1:** BCLK toggles every clk. The gain pipeline still meets the 2-clk setup before capture because inputs are static between upstream samples.

## Structure
- **Package i2s_sound_pkg:** SAMPLE_W=16, VOL_W=4, VOL_UNITY=8, VOL_SHIFT=3, FRAME_SLOTS=32, SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000.
- **Sub-module sound_gain_sat:** instantiated twice (L, R). Contains the multiply, shift, clamp and 2-stage register.
- **Top level:** holds the divider, slot counter, capture register and shift path.

## Test plan
- **Reset:** assert reset_n=0 mid-frame → all outputs 0 immediately; after release with BCLK_DIV=4, first BCLK rise at clk 4 and first fall at clk 8.
- **Unity gain:** vol_l=vol_r=8, L=0x1234, R=0xA5C3 → in the frame after capture, left slots 1..16 carry 0001001000110100 and right slots 17..31 plus next slot 0 carry 1010010111000011; LRCLK toggles at slots 0 and 16.
- **Positive saturation:** vol_l=15, L=0x7000 → transmitted left word 0x7FFF. Negative saturation: vol_r=15, R=0x8000 → transmitted right word 0x8000.
- **Rounding:** vol_l=4, L=−3 → left word 0xFFFE (floor of −1.5); vol_l=0, L=0x7FFF → 0x0000.
- **enable:** drop enable for 100 clks mid-frame → bclk, lrclk, sdata and slot unchanged throughout, frame_start stays 0; on resume, the bit sequence continues exactly where it stopped.
- **Frame period:** BCLK_DIV=2 → frame_start pulses every 128 clks, one clk wide, coincident with the new frame_word.

Source files
------------

// File: rtl/i2s_sound_pkg.sv
// i2s_sound_pkg: shared widths and saturation limits for the I2S sound serializer
package i2s_sound_pkg;
    localparam int SAMPLE_W    = 16;
    localparam int VOL_W       = 4;
    localparam int VOL_UNITY   = 8;
    localparam int VOL_SHIFT   = 3;
    localparam int FRAME_SLOTS = 32;
    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/sound_gain_sat.sv
// sound_gain_sat: per-channel 4-bit gain (unity = 8) with saturation, two-stage registered
module sound_gain_sat
    import i2s_sound_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [VOL_W-1:0]    vol,
    output logic [SAMPLE_W-1:0] gain
);
    localparam int P_W = SAMPLE_W + VOL_W + 1;
    localparam int Q_W = P_W - VOL_SHIFT;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] prod_q;
    logic signed [Q_W-1:0] q;
    logic [SAMPLE_W-1:0]   sat;

    assign prod = $signed(sample) * $signed({1'b0, vol});
    // Dropping the low bits of a signed value is the floor-toward-minus-infinity shift.
    assign q    = prod_q[P_W-1:VOL_SHIFT];
    assign sat  = (q > 18'sd32767) ? SAT_MAX : (q < -18'sd32768) ? SAT_MIN : q[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            gain   <= '0;
        end else if (enable) begin
            prod_q <= prod;
            gain   <= sat;
        end
    end
endmodule

// File: rtl/i2s_sound_serializer.sv
// i2s_sound_serializer: stereo gain stage feeding a Philips I2S transmitter (BCLK/LRCLK/SDATA)
module i2s_sound_serializer
    import i2s_sound_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sound_in_l,
    input  logic [SAMPLE_W-1:0] sound_in_r,
    input  logic [VOL_W-1:0]    vol_l,
    input  logic [VOL_W-1:0]    vol_r,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                frame_start
);
    localparam int SLOT_W = $clog2(FRAME_SLOTS);

    logic [7:0]            div_cnt;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_W-1:0]     slot_nx;
    logic [2*SAMPLE_W-1:0] frame_word;
    logic [SAMPLE_W-1:0]   g_l;
    logic [SAMPLE_W-1:0]   g_r;
    logic                  div_wrap;
    logic                  fall;
    logic                  capture;

    sound_gain_sat u_gain_l (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .sample  (sound_in_l),
        .vol     (vol_l),
        .gain    (g_l)
    );

    sound_gain_sat u_gain_r (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .sample  (sound_in_r),
        .vol     (vol_r),
        .gain    (g_r)
    );

    assign div_wrap = div_cnt == 8'(BCLK_DIV - 1);
    assign fall     = div_wrap && i2s_bclk;
    assign capture  = fall && slot == SLOT_W'(FRAME_SLOTS - 1);
    assign slot_nx  = slot + 1'b1;

    // frame_word doubles as the shift path: its MSB feeds sdata one BCLK late,
    // so after 31 shifts the previous word's LSB lands in the next slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            slot        <= '0;
            frame_word  <= '0;
            i2s_bclk    <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
            i2s_bclk    <= i2s_bclk ^ div_wrap;
            frame_start <= capture;
            if (fall) begin
                slot       <= slot_nx;
                i2s_lrclk  <= slot_nx[SLOT_W-1];
                i2s_sdata  <= frame_word[2*SAMPLE_W-1];
                frame_word <= capture ? {g_l, g_r} : frame_word << 1;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s_sound_serializer.sv
// tb_i2s_sound_serializer: randomized and directed checks of the I2S serializer against a gain model
module tb_i2s_sound_serializer;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] sl, sr;
    logic [3:0]  vl, vr;
    logic        bclk, lrclk, sdata, fs;
    logic        bclk2, lrclk2, sdata2, fs2;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    i2s_sound_serializer #(.BCLK_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sound_in_l(sl), .sound_in_r(sr), .vol_l(vl), .vol_r(vr),
        .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata), .frame_start(fs)
    );

    i2s_sound_serializer #(.BCLK_DIV(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sound_in_l(sl), .sound_in_r(sr), .vol_l(vl), .vol_r(vr),
        .i2s_bclk(bclk2), .i2s_lrclk(lrclk2), .i2s_sdata(sdata2), .frame_start(fs2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Gain as plain integer arithmetic: floor(sample * vol / 8), clamped to 16-bit signed.
    function automatic logic [15:0] ref_gain(input logic [15:0] s, input logic [3:0] v);
        int p;
        p = int'($signed(s)) * int'(v);
        p = p >>> 3;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    // Waits for a capture, then reads the 32 bits sent for that word (slots 1..31 and the next slot 0)
    // at BCLK rising edges, also counting slots whose word select is wrong.
    task automatic get_frame(output logic [31:0] w, output int lr_bad);
        int   t;
        int   n;
        logic pb;
        w = '0;
        lr_bad = 0;
        t = 0;
        while (!fs && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!fs) begin
            check("frame_start_timeout", 32'(fs), 32'd1);
            return;
        end
        pb = bclk;
        n = 0;
        t = 0;
        while (n < 33 && t < 4000) begin
            @(negedge clk);
            t++;
            if (!pb && bclk) begin
                if (n > 0) begin
                    w = {w[30:0], sdata};
                    if (lrclk !== ((n >= 16 && n <= 31) ? 1'b1 : 1'b0)) lr_bad++;
                end
                n++;
            end
            pb = bclk;
        end
        if (n < 33) check("bclk_timeout", 32'(n), 32'd33);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic [3:0] a, input logic [3:0] b, input logic [31:0] exp);
        logic [31:0] w;
        int          lr_bad;
        sl = l; sr = r; vl = a; vr = b;
        get_frame(w, lr_bad);
        check(tag, w, exp);
        check({tag, "_lrclk"}, 32'(lr_bad), 32'd0);
    endtask

    initial begin
        logic [15:0] l, r;
        logic [3:0]  a, b;
        logic [31:0] w;
        int          lr_bad;
        int          t;
        int          bad;
        int          ones;
        int          k;
        logic        hb, hl, hd;

        reset_n = 1'b0; enable = 1'b1;
        sl = 16'h1234; sr = 16'hA5C3; vl = 4'd8; vr = 4'd8;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, bclk, lrclk, sdata, fs}, 32'd0);
        check("reset_outputs2", {28'd0, bclk2, lrclk2, sdata2, fs2}, 32'd0);
        reset_n = 1'b1;

        run_frame("unity",     16'h1234, 16'hA5C3, 4'd8,  4'd8,  32'h1234_A5C3);
        run_frame("sat",       16'h7000, 16'h8000, 4'd15, 4'd15, 32'h7FFF_8000);
        run_frame("round",     16'hFFFD, 16'h0100, 4'd4,  4'd8,  32'hFFFE_0100);
        run_frame("vol_zero",  16'h7FFF, 16'h8000, 4'd0,  4'd0,  32'h0000_0000);
        run_frame("gain_1p5",  16'h4000, 16'hC000, 4'd12, 4'd12, 32'h6000_A000);

        for (int i = 0; i < 8; i++) begin
            l = 16'($urandom); r = 16'($urandom);
            a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
            run_frame($sformatf("rand%0d", i), l, r, a, b, {ref_gain(l, a), ref_gain(r, b)});
        end

        // Freeze for 100 clks in the middle of a frame; the stream must resume bit-exact.
        l = 16'($urandom); r = 16'($urandom); a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
        sl = l; sr = r; vl = a; vr = b;
        bad = 0;
        fork
            get_frame(w, lr_bad);
            begin
                t = 0;
                while (!fs && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (100) @(negedge clk);
                enable = 1'b0;
                hb = bclk; hl = lrclk; hd = sdata;
                repeat (100) begin
                    @(negedge clk);
                    if (bclk !== hb || lrclk !== hl || sdata !== hd || fs !== 1'b0) bad++;
                end
                enable = 1'b1;
            end
        join
        check("enable_hold", 32'(bad), 32'd0);
        check("enable_resume", w, {ref_gain(l, a), ref_gain(r, b)});
        check("enable_lrclk", 32'(lr_bad), 32'd0);

        t = 0;
        while (!fs2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("fs2_width", 32'(fs2), 32'd0);
        t = 1;
        while (!fs2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("fs2_period", 32'(t), 32'd128);

        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("midframe_reset", {28'd0, bclk, lrclk, sdata, fs}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ones = 0;
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 3) check("bclk_clk3", 32'(bclk), 32'd0);
            if (k == 4) check("bclk_rise_clk4", 32'(bclk), 32'd1);
            if (k == 7) check("bclk_clk7", 32'(bclk), 32'd1);
            if (k == 8) check("bclk_fall_clk8", 32'(bclk), 32'd0);
            if (sdata) ones++;
            if (fs) break;
        end
        check("first_capture_clk", 32'(k), 32'd256);
        check("first_frame_zero", 32'(ones), 32'd0);
        get_frame(w, lr_bad);
        check("after_reset", w, {ref_gain(sl, vl), ref_gain(sr, vr)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
